// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: WIDTH-bit adder that adds CHUNK bits per clock through a registered carry.
// Optional macro SUB_EN adds a 'sub' input selecting a - b (co=1 then means no borrow).

module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b;
  assign o_co = i_a & i_b;
endmodule

module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  ha u_ha0 (.i_a(i_a),  .i_b(i_b),  .o_s(w_s1), .o_co(w_c1));
  ha u_ha1 (.i_a(w_s1), .i_b(i_ci), .o_s(o_s),  .o_co(w_c2));

  assign o_co = w_c1 | w_c2;
endmodule

module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_done;

  logic [WIDTH-1:0] w_bLoad;
  logic             w_cLoad;
  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_chunkA;
  logic [CHUNK-1:0] w_chunkB;
  logic [CHUNK-1:0] w_sum;
  logic             w_chunkCo;
  logic             w_last;

  // Subtraction is a + ~b + 1, so it reuses the adder with a forced carry-in.
`ifdef SUB_EN
  assign w_bLoad = sub ? ~b : b;
  assign w_cLoad = sub ? 1'b1 : ci;
`else
  assign w_bLoad = b;
  assign w_cLoad = ci;
`endif

  assign w_base   = 32'(r_k) * 32'(CHUNK);
  assign w_chunkA = CHUNK'(r_a >> w_base);
  assign w_chunkB = CHUNK'(r_b >> w_base);
  assign w_last   = (r_k == KW'(N - 1));

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic w_cin;
      logic w_cout;
      if (i == 0) begin : g_first
        assign w_cin = r_c;
      end else begin : g_next
        assign w_cin = g_bit[i-1].w_cout;
      end
      fa u_fa (
        .i_a (w_chunkA[i]),
        .i_b (w_chunkB[i]),
        .i_ci(w_cin),
        .o_s (w_sum[i]),
        .o_co(w_cout)
      );
    end
  endgenerate

  assign w_chunkCo = g_bit[CHUNK-1].w_cout;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a  <= a;
            r_b  <= w_bLoad;
            r_c  <= w_cLoad;
            r_k  <= '0;
            r_s  <= '0;
            r_co <= 1'b0;
          end
        end
        RUN: begin
          // Only the current chunk's slice of s is replaced; earlier chunks are kept.
          r_s <= (r_s & ~(CHUNK_MASK << w_base)) | (WIDTH'(w_sum) << w_base);
          r_c <= w_chunkCo;
          if (w_last) begin
            r_co   <= w_chunkCo;
            r_done <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench for chunk_serial_adder at CHUNK=4, 1 and 16 (WIDTH=16).
// Expected sums come from plain integer arithmetic; a single monitor checks all three instances.

module tb_chunk_serial_adder;
  localparam int WIDTH = 16;
  localparam int NINST = 3;

  typedef struct {
    int               inst;
    logic [WIDTH-1:0] s;
    logic             co;
    longint           acc;
  } exp_t;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic [NINST-1:0] startW  = '0;
  logic [WIDTH-1:0] a       = '0;
  logic [WIDTH-1:0] b       = '0;
  logic             ci      = 1'b0;
`ifdef SUB_EN
  logic             sub     = 1'b0;
`endif
  logic [NINST-1:0] busyW;
  logic [NINST-1:0] doneW;
  logic [NINST-1:0] coW;
  logic [WIDTH-1:0] sW [NINST];

  exp_t             expQ[$];
  longint           cycle  = 0;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] lastS  [NINST];
  logic             lastCo [NINST];

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(startW[0]), .a(a), .b(b), .ci(ci),
`ifdef SUB_EN
    .sub(sub),
`endif
    .busy(busyW[0]), .done(doneW[0]), .s(sW[0]), .co(coW[0])
  );

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(startW[1]), .a(a), .b(b), .ci(ci),
`ifdef SUB_EN
    .sub(sub),
`endif
    .busy(busyW[1]), .done(doneW[1]), .s(sW[1]), .co(coW[1])
  );

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(startW[2]), .a(a), .b(b), .ci(ci),
`ifdef SUB_EN
    .sub(sub),
`endif
    .busy(busyW[2]), .done(doneW[2]), .s(sW[2]), .co(coW[2])
  );

  function automatic int chunkOf(input int inst);
    case (inst)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int latOf(input int inst);
    return WIDTH / chunkOf(inst);
  endfunction

  function automatic void checkOutput(input string name, input int inst,
                                      input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (CHUNK=%0d, cycle %0d): got 0x%0h, expected 0x%0h",
               name, chunkOf(inst), cycle, actual, expected);
    end
  endfunction

  // Reference: plain unsigned arithmetic on the whole word.
  function automatic exp_t model(input int inst, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic cc, input logic ss);
    exp_t             e;
    logic [WIDTH:0]   full;
    full = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    e.co = full[WIDTH];
    e.s  = full[WIDTH-1:0];
`ifdef SUB_EN
    if (ss) begin
      e.s  = aa - bb;
      e.co = (aa >= bb);
    end
`else
    if (ss) e.inst = inst;
`endif
    e.inst = inst;
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Called just after a falling edge; the following rising edge is the accepting edge.
  task automatic applyStimulus(input int inst, input logic [WIDTH-1:0] aa,
                               input logic [WIDTH-1:0] bb, input logic cc, input logic ss);
    exp_t e;
    a  = aa;
    b  = bb;
    ci = cc;
`ifdef SUB_EN
    sub = ss;
`endif
    startW[inst] = 1'b1;
    e     = model(inst, aa, bb, cc, ss);
    e.acc = cycle + 1;
    expQ.push_back(e);
    @(negedge clock);
    startW[inst] = 1'b0;
  endtask

  task automatic waitDone(input int inst);
    for (int n = 0; n < latOf(inst) + 4; n++) begin
      if (doneW[inst]) return;
      @(negedge clock);
    end
  endtask

  task automatic randomRun(input int inst, input int count);
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;
    for (int k = 0; k < count; k++) begin
      ra = pickOperand();
      rb = pickOperand();
      rc = ($urandom_range(0, 1) == 1);
`ifdef SUB_EN
      rs = ($urandom_range(0, 3) == 0);
`else
      rs = 1'b0;
`endif
      applyStimulus(inst, ra, rb, rc, rs);
      waitDone(inst);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  // Monitor: pops the scoreboard on done, and checks busy and held outputs every cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    logic ownsFront;
    logic expBusy;
    for (int i = 0; i < NINST; i++) begin
      if (!reset_n) begin
        checkOutput("reset busy", i, 32'(busyW[i]), 32'd0);
        checkOutput("reset done", i, 32'(doneW[i]), 32'd0);
        checkOutput("reset s",    i, 32'(sW[i]),    32'd0);
        checkOutput("reset co",   i, 32'(coW[i]),   32'd0);
        lastS[i]  = '0;
        lastCo[i] = 1'b0;
      end else begin
        ownsFront = 1'b0;
        expBusy   = 1'b0;
        if (expQ.size() > 0) begin
          if (expQ[0].inst == i) begin
            ownsFront = 1'b1;
            expBusy   = (cycle >= expQ[0].acc) && (cycle < expQ[0].acc + longint'(latOf(i)));
          end
        end
        checkOutput("busy", i, 32'(busyW[i]), 32'(expBusy));
        if (doneW[i]) begin
          if (ownsFront) begin
            e = expQ.pop_front();
            checkOutput("sum",     i, 32'(sW[i]),           32'(e.s));
            checkOutput("carry",   i, 32'(coW[i]),          32'(e.co));
            checkOutput("latency", i, 32'(cycle - e.acc),   32'(latOf(i)));
            lastS[i]  = e.s;
            lastCo[i] = e.co;
          end else begin
            checkOutput("unexpected done", i, 32'(doneW[i]), 32'd0);
          end
        end else if (ownsFront && (cycle >= expQ[0].acc + longint'(latOf(i)))) begin
          checkOutput("done missing", i, 32'(doneW[i]), 32'd1);
          e = expQ.pop_front();
        end else if (!expBusy) begin
          checkOutput("held s",  i, 32'(sW[i]),  32'(lastS[i]));
          checkOutput("held co", i, 32'(coW[i]), 32'(lastCo[i]));
        end
      end
    end
  end

  initial begin
    $display("[TB] chunk_serial_adder bench starting");
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Directed additions on the CHUNK=4 instance
    applyStimulus(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    waitDone(0);
    @(negedge clock);
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitDone(0);
    @(negedge clock);
    applyStimulus(0, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    waitDone(0);
    repeat (2) @(negedge clock);

    // A second start mid-run must be ignored; a start in the done cycle must be taken
    applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    a  = 16'hFFFF;
    b  = 16'hFFFF;
    ci = 1'b1;
    startW[0] = 1'b1;
    @(negedge clock);
    startW[0] = 1'b0;
    waitDone(0);
    applyStimulus(0, 16'h0F0F, 16'hF0F1, 1'b1, 1'b0);
    waitDone(0);
    repeat (2) @(negedge clock);

    // Reset after the second processing edge discards the operation
    applyStimulus(0, 16'hABCD, 16'h1234, 1'b1, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    expQ.delete();
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clock);

`ifdef SUB_EN
    applyStimulus(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
    waitDone(0);
    @(negedge clock);
    applyStimulus(0, 16'h0007, 16'h0005, 1'b0, 1'b1);
    waitDone(0);
    @(negedge clock);
`endif

    randomRun(0, 300);
    randomRun(1, 1000);
    randomRun(2, 1000);

    repeat (30) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
